seg_scan_controller: RTL
========================

// Module: seg_scan_controller
// PURPOSE
//  Time-multiplexes an N-digit common-anode 7-segment display from a single system clock.
//  An internal enable-tick prescaler replaces divided/derived clocks; the whole block runs on clk.
//  A req/ack shadow-load handshake updates the displayed value only at frame boundaries (tear-free).
//  Sits between the multiplier result/formatting logic and the board's segment decoder.
// PARAMETERS
//  DIGITS    4       number of scanned digits; legal 2..8
//  PRESCALE  100000  clk cycles per digit slot; legal >= 1
//  CW        17      prescaler counter width; must satisfy 2**CW >= PRESCALE
// PORTS
//  clk         in   1          system clock; all logic on its rising edge
//  rst         in   1          asynchronous, active-low reset (asserts immediately, deasserts on clk)
//  en          in   1          1 = scan, 0 = blank display and hold in IDLE
//  load_req    in   1          held high by producer until load_ack; value_in stable while high
//  value_in    in   4*DIGITS   digit codes, digit 0 = bits [3:0]
//  load_ack    out  1          one-cycle pulse: value_in captured into shadow register
//  anode       out  DIGITS     active-low digit enables; exactly one low in SCAN, all high otherwise
//  digit_code  out  4          code of the currently enabled digit (to segment decoder)
//  frame_done  out  1          one-cycle pulse when the last digit slot ends
// BEHAVIOUR
//  Reset (rst=0): state=IDLE, prescaler=0, idx=0, shadow=0, anode=all 1s, digit_code=0,
//   load_ack=0, frame_done=0.
//  States: IDLE, SCAN.
//   IDLE -> SCAN when en=1; on that transition prescaler=0 and idx=0, and shadow<=value_in with
//     load_ack pulsed if load_req=1.
//   SCAN -> IDLE when en=0 (any cycle, mid-slot included). Prescaler and idx are cleared;
//     anode goes all 1s the next cycle. A pending load_req is not acked in IDLE.
//  Prescaler (SCAN only): counts 0..PRESCALE-1 and wraps; tick=1 in the cycle count==PRESCALE-1.
//   PRESCALE=1 gives tick every cycle.
//  On tick: idx <= (idx==DIGITS-1) ? 0 : idx+1.
//   When idx==DIGITS-1 at tick: frame_done pulses in the following cycle.
//   When idx==DIGITS-1 at tick and load_req=1: shadow<=value_in and load_ack pulses in the
//     following cycle.
//  Outputs are registered: anode/digit_code reflect the new idx one cycle after tick.
//   anode = ~(1<<idx); digit_code = shadow[4*idx +: 4].
//  load_req deasserted before ack: request dropped, no ack, shadow unchanged.
//  load_req rising in the same cycle as the frame-boundary tick: captured on that tick.
//  load_ack never pulses on two consecutive cycles; producer must drop load_req after ack.
//  No X on outputs after reset; en toggling has no effect on shadow contents.
// STRUCTURE
//  Package seg_pkg: state enum {IDLE, SCAN}; function anode_onehot_n(idx, DIGITS);
//   localparam ANODE_OFF = all ones.
//  Sub-module tick_gen #(PRESCALE, CW): clk, rst, clr, en -> tick. Enable-pulse prescaler
//   instantiated once; remaining logic (FSM, idx, shadow, handshake) lives in this module.
// TESTING  (DIGITS=4, PRESCALE=4 unless noted)
//  1 Reset mid-scan: drop rst with idx=2 -> anode=4'b1111, digit_code=0, pulses 0, same cycle.
//  2 Scan order: shadow=16'h4321, en=1 -> digit_code 1,2,3,4 on anode 1110,1101,1011,0111,
//    each held 4 cycles; frame_done pulses once per 16 cycles.
//  3 Frame-aligned load: req with 16'hBEEF at idx=1 -> no change until frame end;
//    ack 1 cycle after last-slot tick; next frame shows F,E,E,B.
//  4 Boundary race: req rises in the tick cycle of idx=3 -> captured that tick, ack next cycle.
//    Req dropped before boundary -> no ack, display unchanged.
//  5 en drop mid-slot (idx=2, count=1) -> anode all 1s next cycle. en re-raised with req=1
//    -> ack next cycle, scan restarts at idx=0, count=0.
//  6 PRESCALE=1, DIGITS=2 -> idx alternates every cycle; frame_done every 2nd cycle;
//    no X on outputs.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package seg_pkg;

    localparam int unsigned MAX_DIGITS = 8;
    localparam int unsigned IDX_W      = 3;

    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Active-low one-hot anode pattern; digits beyond the populated count stay off.
    function automatic logic [MAX_DIGITS-1:0] anode_onehot_n(input logic [IDX_W-1:0] idx,
                                                             input int unsigned digits);
        logic [MAX_DIGITS-1:0] r;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            r[i] = !((i == 32'(idx)) && (i < digits));
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_controller_tick_gen.sv
// Enable-pulse prescaler: one-cycle tick every PRESCALE enabled clk cycles.
module tick_gen #(
    parameter int unsigned PRESCALE = 100000,
    parameter int unsigned CW       = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;

    assign tick = en && !clr && (count == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/seg_scan_controller.sv
// N-digit common-anode display scanner with frame-aligned (tear-free) shadow loading.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 100000,
    parameter int unsigned CW       = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load_req,
    input  logic [4*DIGITS-1:0]   value_in,
    output logic                  load_ack,
    output logic [DIGITS-1:0]     anode,
    output logic [3:0]            digit_code,
    output logic                  frame_done
);

    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VW = 4 * DIGITS;
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    state_t              state, state_next;
    logic [IW-1:0]       idx, idx_next;
    logic [VW-1:0]       shadow, shadow_next;
    logic                ack_next, fd_next;
    logic [DIGITS-1:0]   anode_next;
    logic [3:0]          code_next;
    logic                tick, tick_clr, tick_en;

    assign tick_en  = (state == SCAN);
    assign tick_clr = !((state == SCAN) && en);

    tick_gen #(
        .PRESCALE (PRESCALE),
        .CW       (CW)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .en   (tick_en),
        .tick (tick)
    );

    // Next-state, slot index, shadow capture and output pre-computation.
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        shadow_next = shadow;
        ack_next    = 1'b0;
        fd_next     = 1'b0;
        anode_next  = ANODE_OFF[DIGITS-1:0];
        code_next   = '0;

        unique case (state)
            IDLE: begin
                if (en) begin
                    state_next = SCAN;
                    idx_next   = '0;
                    if (load_req) begin
                        shadow_next = value_in;
                        ack_next    = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (!en) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else if (tick) begin
                    if (idx == IDX_LAST) begin
                        idx_next = '0;
                        fd_next  = 1'b1;
                        // load_ack guard keeps the ack a single pulse if req is held too long
                        if (load_req && !load_ack) begin
                            shadow_next = value_in;
                            ack_next    = 1'b1;
                        end
                    end else begin
                        idx_next = idx + IW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_next == SCAN) begin
            anode_next = DIGITS'(anode_onehot_n(IDX_W'(idx_next), DIGITS));
            code_next  = shadow_next[4*idx_next +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            shadow     <= '0;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
            anode      <= ANODE_OFF[DIGITS-1:0];
            digit_code <= '0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            shadow     <= shadow_next;
            load_ack   <= ack_next;
            frame_done <= fd_next;
            anode      <= anode_next;
            digit_code <= code_next;
        end
    end

endmodule
